multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multicycle control FSM for the simplified MIPS core. It replaces single-cycle opcode decode with a per-instruction state sequence.
- Drives PC, IR, memory, register-file, ALU-mux and ALU-op selects over 3–5 cycles per instruction.
- Stalls on a memory ready handshake.
- Sits between the instruction register (opcode source) and the shared datapath/unified memory.

Parameters:
- ALUOP_IO, 2'b00, ALU add (addr calc, addi, PC+4)
- ALUOP_BR, 2'b01, ALU subtract for compare
- ALUOP_R, 2'b10, decode by funct
- ALUOP_I, 2'b11, decode by opcode (slti/andi/ori)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  PC load enable
- ir_write  out  1  IR load enable
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- byte_en  out  1  store is byte-wide (sb)
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- alu_src_a  out  1  0 = PC, 1 = regA
- alu_src_b  out  2  00 = regB, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
- alu_op  out  2  ALU op class
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = exception vector
- reg_write  out  1  register-file write enable
- reg_dst  out  1  1 = rd, 0 = rt
- mem2reg  out  1  1 = write MDR, 0 = write ALUOut
- exception  out  1  illegal-opcode trap pulse
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- state  out  4  current state (debug)

Behaviour:
- State register is asynchronously reset to IDLE; advances on posedge clk. All outputs are decoded combinationally from state, op_q, zero and mem_ready.
- IDLE: every output is 0 (this is the reset value of all outputs). Next state is always FETCH.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=IO, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Captures opcode into op_q.
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=IO (branch target into ALUOut).
  - Next state by opcode:
    - 0 → R_EXEC
    - 35/43/40 → MEM_ADDR
    - 8/10/12/13 → I_EXEC
    - 4/5 → BRANCH
    - 2 → JUMP
    - otherwise → see Optional Feature.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=R. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem2reg=0, instr_done=1. Next state FETCH.
- I_EXEC:
  - alu_src_a=1, alu_src_b=10.
  - alu_op=IO for addi; ALUOP_I for slti/andi/ori.
  - Next state I_WB.
- I_WB: reg_write=1, reg_dst=0, mem2reg=0, instr_done=1. Next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=IO. Next state MEM_RD for lw, MEM_WR for sw/sb.
- MEM_RD: mem_read=1, iord=1. Stay while mem_ready=0; go to MEM_WB when mem_ready=1.
- MEM_WB: reg_write=1, reg_dst=0, mem2reg=1, instr_done=1. Next state FETCH.
- MEM_WR:
  - mem_write=1, iord=1, byte_en=(op_q==40).
  - instr_done equals mem_ready.
  - Stay while mem_ready=0; go to FETCH when mem_ready=1.
  - Request signals are held stable throughout the stall.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=BR, pc_source=01.
  - pc_write = (op_q==4 & zero) | (op_q==5 & ~zero).
  - instr_done=1. Next state FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next state FETCH.
- Latency with mem_ready tied high:
  - R-type, I-type and sw/sb: 4 cycles
  - lw: 5 cycles
  - beq/bne and j: 3 cycles
- Every wait cycle on mem_ready adds exactly one cycle.
- mem_read and mem_write are never asserted in the same cycle.
- Outputs not listed for a state are 0.
- Reset asserted mid-instruction: state goes to IDLE immediately and all outputs drop to 0 asynchronously. No partial write may occur after rst_n falls.
- Unused state encodings go to IDLE.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - Unknown opcode in DECODE goes to EXCEPT.
  - EXCEPT outputs: exception=1, pc_write=1, pc_source=11, instr_done=1. Next state FETCH.
- Undefined:
  - Unknown opcode in DECODE goes directly to FETCH, with instr_done=1 in DECODE (executed as a NOP).
  - exception is tied to 0, and the EXCEPT state does not exist.

Test Plan:
- Reset release, opcode=0, mem_ready=1:
  - State sequence IDLE, FETCH, DECODE, R_EXEC, R_WB, FETCH.
  - reg_write=1 and reg_dst=1 only in R_WB.
  - instr_done pulses once.
- lw (35) with mem_ready held low 2 cycles in FETCH and 3 cycles in MEM_RD:
  - ir_write and pc_write only on the FETCH ready cycle.
  - Total 10 cycles from FETCH entry to FETCH return.
  - mem2reg=1 and reg_write=1 in MEM_WB.
- sb (40) then sw (43):
  - byte_en=1 with mem_write=1 for sb; byte_en=0 for sw.
  - Each instruction takes 4 cycles.
  - reg_write stays 0 throughout.
- beq (4) with zero=1, then bne (5) with zero=1:
  - pc_write=1 with pc_source=01 for beq; pc_write=0 for bne.
  - Each instruction takes 3 cycles.
- rst_n pulled low in MEM_WR with mem_ready=0:
  - mem_write drops to 0 within the same cycle, state=IDLE.
  - After release, FETCH follows one cycle later.
- Opcode 6'd63:
  - With ILLEGAL_OP_TRAP_EN: exception=1 and pc_source=11 for one cycle.
  - Without it: NOP, returns to FETCH after DECODE, exception stays 0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM for the simplified MIPS core: sequences PC/IR/memory/regfile/ALU selects per instruction.
// Optional feature macro: ILLEGAL_OP_TRAP_EN (unknown opcodes trap to EXCEPT instead of executing as a NOP).
module multicycle_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       byte_en,
    output logic       iord,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem2reg,
    output logic       exception,
    output logic       instr_done,
    output logic [3:0] state
);

    localparam logic [1:0] ALUOP_IO = 2'b00;
    localparam logic [1:0] ALUOP_BR = 2'b01;
    localparam logic [1:0] ALUOP_R  = 2'b10;
    localparam logic [1:0] ALUOP_I  = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SB    = 6'd40;
    localparam logic [5:0] OP_SW    = 6'd43;

    // Encodings are visible on the debug state port and are kept fixed.
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        R_EXEC   = 4'd3,
        R_WB     = 4'd4,
        I_EXEC   = 4'd5,
        I_WB     = 4'd6,
        MEM_ADDR = 4'd7,
        MEM_RD   = 4'd8,
        MEM_WB   = 4'd9,
        MEM_WR   = 4'd10,
        BRANCH   = 4'd11,
        JUMP     = 4'd12
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        EXCEPT   = 4'd13
`endif
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                op_q <= opcode;
            end
        end
    end

    assign state = state_q;

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        byte_en    = 1'b0;
        iord       = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALUOP_IO;
        pc_source  = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem2reg    = 1'b0;
        exception  = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // Branch target is computed speculatively into ALUOut here.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:                          state_d = R_EXEC;
                    OP_LW, OP_SW, OP_SB:               state_d = MEM_ADDR;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = I_EXEC;
                    OP_BEQ, OP_BNE:                    state_d = BRANCH;
                    OP_J:                              state_d = JUMP;
                    default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                        state_d = EXCEPT;
`else
                        instr_done = 1'b1;
                        state_d    = FETCH;
`endif
                    end
                endcase
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_R;
                state_d   = R_WB;
            end
            R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (op_q == OP_ADDI) ? ALUOP_IO : ALUOP_I;
                state_d   = I_WB;
            end
            I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op_q == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem2reg    = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEM_WR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                byte_en    = (op_q == OP_SB);
                instr_done = mem_ready;
                state_d    = mem_ready ? FETCH : MEM_WR;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_BR;
                pc_source  = 2'b01;
                pc_write   = ((op_q == OP_BEQ) & zero) | ((op_q == OP_BNE) & ~zero);
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            EXCEPT: begin
                exception  = 1'b1;
                pc_write   = 1'b1;
                pc_source  = 2'b11;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: instruction-level model feeding an expected-output queue checked every cycle.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, mem_read, mem_write, byte_en, iord, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       reg_write, reg_dst, mem2reg, exception, instr_done;
    logic [3:0] state;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_R_EXEC = 4'd3,
                           S_R_WB = 4'd4, S_I_EXEC = 4'd5, S_I_WB = 4'd6, S_MEM_ADDR = 4'd7,
                           S_MEM_RD = 4'd8, S_MEM_WB = 4'd9, S_MEM_WR = 4'd10, S_BRANCH = 4'd11,
                           S_JUMP = 4'd12, S_EXCEPT = 4'd13;

    typedef struct packed {
        logic       pc_write, ir_write, mem_read, mem_write, byte_en, iord, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic       reg_write, reg_dst, mem2reg, exception, instr_done;
        logic [3:0] state;
    } out_t;

    localparam int W = 22;

    logic [W-1:0] act;
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           checks = 0;
    int           errors = 0;
    int           done_count = 0;
    int           cyc;

    multicycle_sequencer dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .byte_en(byte_en), .iord(iord), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem2reg(mem2reg), .exception(exception), .instr_done(instr_done), .state(state)
    );

    assign act = {pc_write, ir_write, mem_read, mem_write, byte_en, iord, alu_src_a,
                  alu_src_b, alu_op, pc_source, reg_write, reg_dst, mem2reg, exception,
                  instr_done, state};

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard: compare on the falling edge, away from the active edge
    always @(negedge clk) begin : cmp
        logic [W-1:0] e;
        string        t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s got %h expected %h (t=%0t)", t, act, e, $time);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && instr_done) done_count++;
    end

    task automatic chk(input string t, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", t, got, expv);
        end
    endtask

    // driver: apply inputs for one cycle and queue what the outputs must be
    task automatic step(input logic mr, input logic z, input out_t e, input string t);
        mem_ready = mr;
        zero      = z;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    // instruction-level model: fw/mw = wait cycles on mem_ready in fetch / data access
    task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                             output int n);
        out_t e;
        n = 0;
        opcode = op;
        for (int i = 0; i <= fw; i++) begin
            e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.state = S_FETCH;
            e.ir_write = (i == fw); e.pc_write = (i == fw);
            step(i == fw, z, e, "fetch"); n++;
        end
        e = '0; e.alu_src_b = 2'b11; e.state = S_DECODE;
        case (op)
            6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd10, 6'd12, 6'd13, 6'd35, 6'd40, 6'd43: begin
                step(1'b1, z, e, "decode"); n++;
            end
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                step(1'b1, z, e, "decode_ill"); n++;
                e = '0; e.exception = 1'b1; e.pc_write = 1'b1; e.pc_source = 2'b11;
                e.instr_done = 1'b1; e.state = S_EXCEPT;
                step(1'b1, z, e, "except"); n++;
`else
                e.instr_done = 1'b1;
                step(1'b1, z, e, "decode_nop"); n++;
`endif
            end
        endcase
        case (op)
            6'd0: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b10; e.state = S_R_EXEC;
                step(1'b1, z, e, "r_exec"); n++;
                e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1; e.instr_done = 1'b1; e.state = S_R_WB;
                step(1'b1, z, e, "r_wb"); n++;
            end
            6'd8, 6'd10, 6'd12, 6'd13: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                e.alu_op = (op == 6'd8) ? 2'b00 : 2'b11; e.state = S_I_EXEC;
                step(1'b1, z, e, "i_exec"); n++;
                e = '0; e.reg_write = 1'b1; e.instr_done = 1'b1; e.state = S_I_WB;
                step(1'b1, z, e, "i_wb"); n++;
            end
            6'd35, 6'd40, 6'd43: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.state = S_MEM_ADDR;
                step(1'b1, z, e, "mem_addr"); n++;
                for (int i = 0; i <= mw; i++) begin
                    e = '0; e.iord = 1'b1;
                    if (op == 6'd35) begin
                        e.mem_read = 1'b1; e.state = S_MEM_RD;
                        step(i == mw, z, e, "mem_rd"); n++;
                    end else begin
                        e.mem_write = 1'b1; e.byte_en = (op == 6'd40);
                        e.instr_done = (i == mw); e.state = S_MEM_WR;
                        step(i == mw, z, e, "mem_wr"); n++;
                    end
                end
                if (op == 6'd35) begin
                    e = '0; e.reg_write = 1'b1; e.mem2reg = 1'b1; e.instr_done = 1'b1;
                    e.state = S_MEM_WB;
                    step(1'b1, z, e, "mem_wb"); n++;
                end
            end
            6'd4, 6'd5: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_source = 2'b01;
                e.pc_write = (op == 6'd4) ? z : ~z; e.instr_done = 1'b1; e.state = S_BRANCH;
                step(1'b1, z, e, "branch"); n++;
            end
            6'd2: begin
                e = '0; e.pc_write = 1'b1; e.pc_source = 2'b10; e.instr_done = 1'b1;
                e.state = S_JUMP;
                step(1'b1, z, e, "jump"); n++;
            end
            default: ;
        endcase
    endtask

    initial begin : main
        out_t e;
        rst_n = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {10'd0, act}, 32'd0);
        rst_n = 1'b1;
        e = '0; e.state = S_IDLE;
        step(1'b1, 1'b0, e, "idle");

        run_instr(6'd0, 1'b0, 0, 0, cyc);  chk("rtype_cycles", cyc, 4);
        chk("rtype_done_pulses", done_count, 1);
        run_instr(6'd35, 1'b0, 2, 3, cyc); chk("lw_stall_cycles", cyc, 10);
        run_instr(6'd40, 1'b0, 0, 0, cyc); chk("sb_cycles", cyc, 4);
        run_instr(6'd43, 1'b0, 0, 0, cyc); chk("sw_cycles", cyc, 4);
        run_instr(6'd8, 1'b0, 0, 0, cyc);  chk("addi_cycles", cyc, 4);
        run_instr(6'd13, 1'b0, 0, 0, cyc); chk("ori_cycles", cyc, 4);
        run_instr(6'd4, 1'b1, 0, 0, cyc);  chk("beq_taken_cycles", cyc, 3);
        run_instr(6'd5, 1'b1, 0, 0, cyc);  chk("bne_nottaken_cycles", cyc, 3);
        run_instr(6'd4, 1'b0, 0, 0, cyc);
        run_instr(6'd5, 1'b0, 0, 0, cyc);
        run_instr(6'd2, 1'b0, 0, 0, cyc);  chk("j_cycles", cyc, 3);
        run_instr(6'd63, 1'b0, 0, 0, cyc);
`ifdef ILLEGAL_OP_TRAP_EN
        chk("illegal_trap_cycles", cyc, 3);
`else
        chk("illegal_nop_cycles", cyc, 2);
`endif

        // asynchronous reset while a store is stalled in MEM_WR
        opcode = 6'd43;
        e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = 1'b1; e.pc_write = 1'b1;
        e.state = S_FETCH;
        step(1'b1, 1'b0, e, "rst_fetch");
        e = '0; e.alu_src_b = 2'b11; e.state = S_DECODE;
        step(1'b1, 1'b0, e, "rst_decode");
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.state = S_MEM_ADDR;
        step(1'b1, 1'b0, e, "rst_mem_addr");
        mem_ready = 1'b0;
        e = '0; e.mem_write = 1'b1; e.iord = 1'b1; e.state = S_MEM_WR;
        exp_q.push_back(e); tag_q.push_back("rst_mem_wr_stall");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_write_drop", {31'd0, mem_write}, 32'd0);
        chk("rst_state_idle", {28'd0, state}, {28'd0, S_IDLE});
        chk("rst_all_outputs", {10'd0, act}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        e = '0; e.state = S_IDLE;
        step(1'b1, 1'b0, e, "idle_after_rst");
        run_instr(6'd0, 1'b0, 0, 0, cyc);  chk("rtype_after_rst_cycles", cyc, 4);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        chk("instr_done_pulses", done_count, 13);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
